// File: rtl/approx_mul_pkg.sv
// Shared types for the shared 8x8 multiplier scheduler: operand/result stage
// records and the exact/approximate mode encoding.
package approx_mul_pkg;
    localparam int W       = 8;
    localparam int ZW      = 2 * W;
    localparam int IDW_MAX = 3;   // wide enough for up to 8 requesters

    typedef enum logic {
        MODE_APX   = 1'b0,
        MODE_EXACT = 1'b1
    } mul_mode_e;

    typedef struct packed {
        logic [W-1:0]       x;
        logic [W-1:0]       y;
        mul_mode_e          mode;
        logic [IDW_MAX-1:0] id;
    } s1_t;

    typedef struct packed {
        logic [ZW-1:0]      z;
        mul_mode_e          mode;
        logic [IDW_MAX-1:0] id;
    } s2_t;
endpackage

// File: rtl/approx_mul_rr_scheduler_if.sv
// Requester-side and response-side handshake bundle of the multiplier scheduler.
interface approx_mul_rr_scheduler_if #(
    parameter int NREQ = 4,
    parameter int W    = 8
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ*W-1:0] req_y;
    logic [NREQ-1:0]   req_exact;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2*W-1:0]    rsp_z;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_exact;
    logic              busy;

    modport slave (
        input  req_valid, req_x, req_y, req_exact, rsp_ready,
        output req_ready, rsp_valid, rsp_z, rsp_id, rsp_exact, busy
    );

    modport master (
        output req_valid, req_x, req_y, req_exact, rsp_ready,
        input  req_ready, rsp_valid, rsp_z, rsp_id, rsp_exact, busy
    );
endinterface

// File: rtl/approx_mul_core.sv
// Combinational 8x8 unsigned multiplier: exact product or the l=2 approximation
// where the two low partial-product rows are folded into a few OR/AND terms.
module approx_mul_core
    import approx_mul_pkg::*;
(
    input  logic [W-1:0]  x_i,
    input  logic [W-1:0]  y_i,
    input  logic          exact_i,
    output logic [ZW-1:0] z_o
);
    logic [W-1:0]  p1, p2;
    logic [ZW-1:0] hi, c1, c2;

    always_comb begin
        p1  = y_i & {W{x_i[0]}};
        p2  = y_i & {W{x_i[1]}};
        hi  = (ZW'(y_i) * ZW'(x_i[W-1:2])) << 2;
        // Compressed contribution of rows x[0] and x[1], aligned at bit 6.
        c1  = {7'b0, p2[7], p1[7] & p2[6], p1[6] | p2[5], 6'b0};
        c2  = {8'b0, p1[7] | p2[6], p1[5] | p2[4], 6'b0};
        z_o = exact_i ? ZW'(x_i) * ZW'(y_i) : hi + c1 + c2;
    end
endmodule

// File: rtl/approx_mul_rr_scheduler.sv
// Round-robin front end sharing one multiplier among NREQ requesters through a
// 2-stage (operand reg -> product reg) pipeline with valid/ready on both sides.
module approx_mul_rr_scheduler
    import approx_mul_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    approx_mul_rr_scheduler_if.slave    sched_io
);
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d, gnt, idx;
    logic [IDW:0]   sum;
    logic           gnt_found, stall2, adv1, s1_free, accept;
    logic           s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
    s1_t            s1_q, s1_d;
    s2_t            s2_q, s2_d;
    logic [ZW-1:0]  z;

    approx_mul_core u_core (
        .x_i     (s1_q.x),
        .y_i     (s1_q.y),
        .exact_i (s1_q.mode == MODE_EXACT),
        .z_o     (z)
    );

    assign stall2  = s2_vld_q & ~sched_io.rsp_ready;
    assign adv1    = s1_vld_q & ~stall2;
    assign s1_free = ~s1_vld_q | adv1;
    assign accept  = gnt_found & s1_free & ~rst;

    // First valid requester at or after rr_ptr, wrapping at NREQ-1.
    always_comb begin
        gnt       = '0;
        gnt_found = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
            idx = sum[IDW-1:0];
            if (!gnt_found && sched_io.req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt       = idx;
            end
        end
        sched_io.req_ready = '0;
        if (accept) sched_io.req_ready[gnt] = 1'b1;
    end

    always_comb begin
        s1_d     = s1_q;
        s1_vld_d = s1_vld_q & ~adv1;
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            s1_d.x    = sched_io.req_x[gnt*W +: W];
            s1_d.y    = sched_io.req_y[gnt*W +: W];
            s1_d.mode = mul_mode_e'(sched_io.req_exact[gnt]);
            s1_d.id   = IDW_MAX'(gnt);
            s1_vld_d  = 1'b1;
            rr_ptr_d  = (gnt == IDW'(NREQ-1)) ? '0 : gnt + IDW'(1);
        end
        s2_d     = s2_q;
        s2_vld_d = s2_vld_q;
        // Refill from s1 takes priority so a drain and a refill share one cycle.
        if (adv1) begin
            s2_d.z    = z;
            s2_d.mode = s1_q.mode;
            s2_d.id   = s1_q.id;
            s2_vld_d  = 1'b1;
        end else if (sched_io.rsp_ready) begin
            s2_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            rr_ptr_q <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
            rr_ptr_q <= rr_ptr_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
        end
    end

    assign sched_io.rsp_valid = s2_vld_q;
    assign sched_io.rsp_z     = s2_q.z;
    assign sched_io.rsp_id    = s2_q.id[IDW-1:0];
    assign sched_io.rsp_exact = s2_q.mode;
    assign sched_io.busy      = s1_vld_q | s2_vld_q;
endmodule

// File: tb/tb_approx_mul_rr_scheduler.sv
// Directed bench for the round-robin multiplier scheduler: reset, exact and
// approximate products, fairness, backpressure and reset mid-operation.
module tb_approx_mul_rr_scheduler;
    localparam int NREQ = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    approx_mul_rr_scheduler_if #(.NREQ(NREQ), .W(8)) bus ();

    approx_mul_rr_scheduler #(.NREQ(NREQ)) dut (
        .clk      (clk),
        .rst      (rst),
        .sched_io (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         port;
        logic [7:0] x;
        logic [7:0] y;
        logic       exact;
        logic [15:0] z;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input int p, input logic [7:0] x, input logic [7:0] y, input logic e);
        bus.req_x[p*8 +: 8] = x;
        bus.req_y[p*8 +: 8] = y;
        bus.req_exact[p]    = e;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rsp(input string name, input logic [15:0] z, input int id, input logic e);
        chk({name, "_valid"}, 32'(bus.rsp_valid), 32'(1));
        chk({name, "_z"},     32'(bus.rsp_z),     32'(z));
        chk({name, "_id"},    32'(bus.rsp_id),    32'(id));
        chk({name, "_exact"}, 32'(bus.rsp_exact), 32'(e));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{2, 8'd200, 8'd100, 1'b1, 16'd20000};
        vecs[1] = '{1, 8'd255, 8'd255, 1'b0, 16'd64900};
        vecs[2] = '{0, 8'd3,   8'd5,   1'b0, 16'd0};
        vecs[3] = '{2, 8'd255, 8'd255, 1'b1, 16'd65025};
        vecs[4] = '{0, 8'd0,   8'd200, 1'b1, 16'd0};
        vecs[5] = '{1, 8'd13,  8'd11,  1'b0, 16'd132};
        vecs[6] = '{0, 8'd1,   8'd96,  1'b0, 16'd128};
        vecs[7] = '{3, 8'd4,   8'd7,   1'b0, 16'd28};
        vecs[8] = '{3, 8'd2,   8'd192, 1'b0, 16'd384};

        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.req_exact = '0;
        bus.rsp_ready = 1'b1;

        // Reset state with every requester asking
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) drive(i, 8'(10 + i), 8'(3 + i), 1'b1);
        bus.req_valid = 4'hF;
        @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'(0));
        chk("rst_valid", 32'(bus.rsp_valid), 32'(0));
        chk("rst_busy",  32'(bus.busy),      32'(0));
        chk("rst_z",     32'(bus.rsp_z),     32'(0));
        chk("rst_id",    32'(bus.rsp_id),    32'(0));
        chk("rst_exact", 32'(bus.rsp_exact), 32'(0));

        // Fairness: all ports valid, one grant and one result per cycle
        step;
        rst = 1'b0;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (c < 8)
                chk($sformatf("rr_grant%0d", c), 32'(bus.req_ready), 32'(1 << (c % 4)));
            if (c >= 2 && c < 10)
                chk_rsp($sformatf("rr_rsp%0d", c), 16'((10 + (c-2)%4) * (3 + (c-2)%4)), (c-2)%4, 1'b1);
            if (c == 10) begin
                chk("rr_valid_end", 32'(bus.rsp_valid), 32'(0));
                chk("rr_busy_end",  32'(bus.busy),      32'(0));
            end
            if (c == 7) begin
                step;
                bus.req_valid = '0;
            end
        end

        // Single requests, exact and approximate
        foreach (vecs[i]) begin
            step;
            drive(vecs[i].port, vecs[i].x, vecs[i].y, vecs[i].exact);
            bus.req_valid = 4'(1 << vecs[i].port);
            @(negedge clk);
            chk($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'(1 << vecs[i].port));
            step;
            bus.req_valid = '0;
            @(negedge clk);
            chk($sformatf("v%0d_early", i), 32'(bus.rsp_valid), 32'(0));
            @(negedge clk);
            chk_rsp($sformatf("v%0d", i), vecs[i].z, vecs[i].port, vecs[i].exact);
        end

        // Backpressure with both stages full
        step;
        bus.rsp_ready = 1'b0;
        drive(0, 8'd5, 8'd6,  1'b1);
        drive(1, 8'd7, 8'd8,  1'b1);
        drive(2, 8'd9, 8'd10, 1'b1);
        bus.req_valid = 4'b0111;
        @(negedge clk);
        chk("bp_grant0", 32'(bus.req_ready), 32'(4'b0001));
        step;
        bus.req_valid = 4'b0110;
        @(negedge clk);
        chk("bp_grant1", 32'(bus.req_ready), 32'(4'b0010));
        step;
        bus.req_valid = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("bp_stall_ready%0d", c), 32'(bus.req_ready), 32'(0));
            chk_rsp($sformatf("bp_hold%0d", c), 16'd30, 0, 1'b1);
            if (c < 2) step;
        end
        step;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_grant2", 32'(bus.req_ready), 32'(4'b0100));
        chk_rsp("bp_out0", 16'd30, 0, 1'b1);
        step;
        bus.req_valid = '0;
        @(negedge clk);
        chk_rsp("bp_out1", 16'd56, 1, 1'b1);
        @(negedge clk);
        chk_rsp("bp_out2", 16'd90, 2, 1'b1);
        @(negedge clk);
        chk("bp_valid_end", 32'(bus.rsp_valid), 32'(0));
        chk("bp_busy_end",  32'(bus.busy),      32'(0));

        // Reset with both stages holding operations
        step;
        bus.rsp_ready = 1'b0;
        drive(0, 8'd11, 8'd11, 1'b1);
        drive(1, 8'd12, 8'd12, 1'b1);
        bus.req_valid = 4'b0011;
        @(negedge clk);
        chk("rm_grant0", 32'(bus.req_ready), 32'(4'b0001));
        step;
        bus.req_valid = 4'b0010;
        @(negedge clk);
        chk("rm_grant1", 32'(bus.req_ready), 32'(4'b0010));
        step;
        bus.req_valid = '0;
        @(negedge clk);
        chk("rm_full_busy",  32'(bus.busy),      32'(1));
        chk("rm_full_valid", 32'(bus.rsp_valid), 32'(1));
        #2;
        bus.req_valid = 4'hF;
        rst = 1'b1;
        #1;
        chk("rm_async_valid", 32'(bus.rsp_valid), 32'(0));
        chk("rm_async_busy",  32'(bus.busy),      32'(0));
        chk("rm_async_ready", 32'(bus.req_ready), 32'(0));
        step;
        rst           = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("rm_discard%0d", c), 32'(bus.rsp_valid), 32'(0));
        end
        step;
        drive(1, 8'd3, 8'd3, 1'b1);
        drive(2, 8'd4, 8'd4, 1'b1);
        drive(3, 8'd5, 8'd5, 1'b1);
        bus.req_valid = 4'b1110;
        @(negedge clk);
        chk("rm_ptr_restart", 32'(bus.req_ready), 32'(4'b0010));
        step;
        bus.req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        chk_rsp("rm_after", 16'd9, 1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
